// File: rtl/glitch_sweep_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : glitch_sweep_sequencer_if
// Description : Bundles the campaign settings, glitch-chain and UART TX
//               signals of the glitch sweep sequencer. The slave modport is
//               the sequencer's view; the master modport is the surrounding
//               command processor / reset / counter / UART side.
// Revision    : 1.0 - initial release
// ============================================================================
interface glitch_sweep_sequencer_if;
    // Campaign control and settings from the command processor
    logic        start;
    logic        abort;
    logic [31:0] ofs_base;
    logic [31:0] ofs_step;
    logic [31:0] glitch_dur;
    logic [15:0] attempts;
    // Feedback from the duration counter and the UART transmitter
    logic        pulse_done;
    logic        tx_busy;
    // Drive towards the glitch chain and the UART transmitter
    logic        tgt_reset;
    logic        start_offset;
    logic [31:0] glitch_offset;
    logic [31:0] glitch_duration;
    logic        tx_start;
    logic [7:0]  tx_data;
    // Campaign status
    logic [15:0] attempt_idx;
    logic        busy;
    logic        done;

    modport slave (
        input  start, abort, ofs_base, ofs_step, glitch_dur, attempts,
        input  pulse_done, tx_busy,
        output tgt_reset, start_offset, glitch_offset, glitch_duration,
        output tx_start, tx_data, attempt_idx, busy, done
    );

    modport master (
        output start, abort, ofs_base, ofs_step, glitch_dur, attempts,
        output pulse_done, tx_busy,
        input  tgt_reset, start_offset, glitch_offset, glitch_duration,
        input  tx_start, tx_data, attempt_idx, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/glitch_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : glitch_sweep_sequencer
// Description : Runs a glitch campaign of N attempts. Each attempt resets the
//               target, lets it settle, arms the offset counter with a swept
//               offset (base + k*step), waits for pulse_done (or times out)
//               and reports the attempt as one ACK/NAK byte over UART TX.
// Revision    : 1.0 - initial release
// ============================================================================
module glitch_sweep_sequencer #(
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  ACK_BYTE       = 8'h55,
    parameter logic [7:0]  NAK_BYTE       = 8'hEE
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    glitch_sweep_sequencer_if.slave   bus
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RST_HOLD = 4'd1,
        S_SETTLE   = 4'd2,
        S_ARM      = 4'd3,
        S_WAIT_PD  = 4'd4,
        S_TX_WAIT  = 4'd5,
        S_TX_GO    = 4'd6,
        S_TX_DRAIN = 4'd7,
        S_NEXT     = 4'd8
    } state_t;

    state_t      state_q;
    logic [31:0] cnt_q;          // shared phase counter (hold/settle/timeout/drain)
    logic [31:0] step_q;
    logic [15:0] attempts_q;
    logic        pd_prev_q;      // pulse_done one cycle ago, for edge detection
    logic        seen_busy_q;    // UART raised tx_busy after our tx_start
    logic        tgt_reset_q;
    logic        start_offset_q;
    logic [31:0] offset_q;
    logic [31:0] dur_q;
    logic        tx_start_q;
    logic [7:0]  tx_data_q;
    logic [15:0] idx_q;
    logic        busy_q;
    logic        done_q;

    // Campaign state machine; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= 32'd0;
            step_q         <= 32'd0;
            attempts_q     <= 16'd0;
            pd_prev_q      <= 1'b0;
            seen_busy_q    <= 1'b0;
            tgt_reset_q    <= 1'b0;
            start_offset_q <= 1'b0;
            offset_q       <= 32'd0;
            dur_q          <= 32'd0;
            tx_start_q     <= 1'b0;
            tx_data_q      <= 8'd0;
            idx_q          <= 16'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            // Pulse outputs are high for a single cycle unless re-asserted below
            done_q         <= 1'b0;
            start_offset_q <= 1'b0;
            tx_start_q     <= 1'b0;
            pd_prev_q      <= bus.pulse_done;

            if (state_q != S_IDLE && bus.abort) begin
                // Abort wins over every other transition; no done pulse
                state_q     <= S_IDLE;
                tgt_reset_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            step_q     <= bus.ofs_step;
                            attempts_q <= bus.attempts;
                            offset_q   <= bus.ofs_base;
                            dur_q      <= bus.glitch_dur;
                            idx_q      <= 16'd0;
                            cnt_q      <= 32'd0;
                            if (bus.attempts == 16'd0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q     <= S_RST_HOLD;
                                tgt_reset_q <= 1'b1;
                                busy_q      <= 1'b1;
                            end
                        end
                    end
                    S_RST_HOLD: begin
                        pd_prev_q <= 1'b0;
                        if (cnt_q == RESET_CYCLES - 1) begin
                            state_q     <= S_SETTLE;
                            tgt_reset_q <= 1'b0;
                            cnt_q       <= 32'd0;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt_q == SETTLE_CYCLES - 1) begin
                            state_q        <= S_ARM;
                            start_offset_q <= 1'b1;
                            cnt_q          <= 32'd0;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    S_ARM: begin
                        state_q <= S_WAIT_PD;
                        cnt_q   <= 32'd0;
                    end
                    S_WAIT_PD: begin
                        // A fresh rising edge beats a timeout in the same cycle
                        if (bus.pulse_done && !pd_prev_q) begin
                            tx_data_q <= ACK_BYTE;
                            state_q   <= S_TX_WAIT;
                        end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
                            tx_data_q <= NAK_BYTE;
                            state_q   <= S_TX_WAIT;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    S_TX_WAIT: begin
                        if (!bus.tx_busy) begin
                            state_q    <= S_TX_GO;
                            tx_start_q <= 1'b1;
                        end
                    end
                    S_TX_GO: begin
                        state_q     <= S_TX_DRAIN;
                        cnt_q       <= 32'd0;
                        seen_busy_q <= 1'b0;
                    end
                    S_TX_DRAIN: begin
                        // A UART that never raises busy within two cycles is
                        // assumed to have taken the byte already
                        if (bus.tx_busy) begin
                            seen_busy_q <= 1'b1;
                        end else if (seen_busy_q || cnt_q == 32'd1) begin
                            state_q <= S_NEXT;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    S_NEXT: begin
                        if (idx_q == attempts_q - 16'd1) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q     <= S_RST_HOLD;
                            idx_q       <= idx_q + 16'd1;
                            offset_q    <= offset_q + step_q;
                            tgt_reset_q <= 1'b1;
                            cnt_q       <= 32'd0;
                        end
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        tgt_reset_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.tgt_reset       = tgt_reset_q;
    assign bus.start_offset    = start_offset_q;
    assign bus.glitch_offset   = offset_q;
    assign bus.glitch_duration = dur_q;
    assign bus.tx_start        = tx_start_q;
    assign bus.tx_data         = tx_data_q;
    assign bus.attempt_idx     = idx_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;

endmodule
`default_nettype wire

// File: tb/tb_glitch_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_glitch_sweep_sequencer
// Description : Self-checking bench for glitch_sweep_sequencer. A timeline
//               model of the campaign predicts every output each cycle; event
//               logs are also compared against hand-computed cycle numbers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glitch_sweep_sequencer;

    localparam int unsigned C_RESET   = 4;
    localparam int unsigned C_SETTLE  = 8;
    localparam int unsigned C_TIMEOUT = 100;
    localparam int          C_UARTLEN = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    glitch_sweep_sequencer_if bus();

    glitch_sweep_sequencer #(
        .RESET_CYCLES   (C_RESET),
        .SETTLE_CYCLES  (C_SETTLE),
        .TIMEOUT_CYCLES (C_TIMEOUT),
        .ACK_BYTE       (8'h55),
        .NAK_BYTE       (8'hEE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- UART and duration-counter stand-ins ----------------
    logic busy_auto = 1'b0;
    logic busy_force = 1'b0;
    int   pd_mode = 1;
    assign bus.tx_busy = busy_auto | busy_force;

    // UART: busy for C_UARTLEN cycles starting the cycle after tx_start
    initial forever begin
        @(negedge clk);
        if (bus.tx_start === 1'b1) begin
            @(negedge clk);
            busy_auto = 1'b1;
            repeat (C_UARTLEN) @(negedge clk);
            busy_auto = 1'b0;
        end
    end

    // pulse_done responder keyed on start_offset
    // mode 0: never; 1: rise 20 cycles later; 2: already high, fall, rise again
    // mode 3: rise 5 cycles later while tx_busy is forced high for 36 cycles
    initial forever begin
        @(negedge clk);
        if (bus.start_offset === 1'b1) begin
            case (pd_mode)
                1: begin
                    repeat (20) @(negedge clk);
                    bus.pulse_done = 1'b1;
                    repeat (3) @(negedge clk);
                    bus.pulse_done = 1'b0;
                end
                2: begin
                    bus.pulse_done = 1'b1;
                    repeat (10) @(negedge clk);
                    bus.pulse_done = 1'b0;
                    repeat (5) @(negedge clk);
                    bus.pulse_done = 1'b1;
                    repeat (3) @(negedge clk);
                    bus.pulse_done = 1'b0;
                end
                3: begin
                    busy_force = 1'b1;
                    repeat (5) @(negedge clk);
                    bus.pulse_done = 1'b1;
                    repeat (3) @(negedge clk);
                    bus.pulse_done = 1'b0;
                    repeat (28) @(negedge clk);
                    busy_force = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // ---------------- Timeline model of the campaign ----------------
    logic        m_tgt_reset, m_start_offset, m_tx_start, m_busy, m_done;
    logic [31:0] m_glitch_offset, m_glitch_duration, m_step;
    logic [7:0]  m_tx_data;
    logic [15:0] m_attempt_idx;
    int          m_n;
    bit          m_pd_cur, m_pd_prev;

    task automatic model_reset();
        m_tgt_reset = 0; m_start_offset = 0; m_tx_start = 0; m_busy = 0; m_done = 0;
        m_glitch_offset = 0; m_glitch_duration = 0; m_step = 0; m_tx_data = 0;
        m_attempt_idx = 0; m_n = 0; m_pd_cur = 0; m_pd_prev = 0;
    endtask

    // One clock edge; stop=1 when reset or abort ends the campaign here
    task automatic tick(output bit stop);
        @(posedge clk);
        m_pd_prev = m_pd_cur;
        m_pd_cur  = bus.pulse_done;
        m_done = 0; m_start_offset = 0; m_tx_start = 0;
        stop = 0;
        if (rst) begin
            model_reset();
            stop = 1;
        end else if (m_busy && bus.abort) begin
            m_tgt_reset = 0;
            m_busy = 0;
            stop = 1;
        end
    endtask

    task automatic campaign();
        bit stop;
        bit seen;
        int w;
        int d;
        for (int k = 0; k < m_n; k++) begin
            for (int i = 0; i < int'(C_RESET); i++) begin tick(stop); if (stop) return; end
            m_tgt_reset = 0;
            for (int i = 0; i < int'(C_SETTLE); i++) begin tick(stop); if (stop) return; end
            m_start_offset = 1;
            tick(stop); if (stop) return;
            w = 0;
            forever begin
                tick(stop); if (stop) return;
                w++;
                if (m_pd_cur && !m_pd_prev) begin m_tx_data = 8'h55; break; end
                if (w == int'(C_TIMEOUT)) begin m_tx_data = 8'hEE; break; end
            end
            forever begin
                tick(stop); if (stop) return;
                if (!bus.tx_busy) break;
            end
            m_tx_start = 1;
            tick(stop); if (stop) return;
            seen = 0;
            d = 0;
            forever begin
                tick(stop); if (stop) return;
                if (bus.tx_busy) seen = 1;
                else if (seen || d == 1) break;
                d++;
            end
            tick(stop); if (stop) return;
            if (k == m_n - 1) begin
                m_done = 1;
                m_busy = 0;
            end else begin
                m_attempt_idx = m_attempt_idx + 16'd1;
                m_glitch_offset = m_glitch_offset + m_step;
                m_tgt_reset = 1;
            end
        end
    endtask

    // Model: idle until an accepted start, then play the campaign timeline
    initial begin
        bit stop;
        model_reset();
        forever begin
            tick(stop);
            if (!stop && bus.start && !bus.abort) begin
                m_glitch_offset   = bus.ofs_base;
                m_glitch_duration = bus.glitch_dur;
                m_step            = bus.ofs_step;
                m_attempt_idx     = 0;
                m_n               = int'(bus.attempts);
                if (m_n == 0) begin
                    m_done = 1;
                end else begin
                    m_busy = 1;
                    m_tgt_reset = 1;
                    campaign();
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tgt_reset",       {31'd0, bus.tgt_reset},       {31'd0, m_tgt_reset});
            chk("start_offset",    {31'd0, bus.start_offset},    {31'd0, m_start_offset});
            chk("glitch_offset",   bus.glitch_offset,            m_glitch_offset);
            chk("glitch_duration", bus.glitch_duration,          m_glitch_duration);
            chk("tx_start",        {31'd0, bus.tx_start},        {31'd0, m_tx_start});
            chk("tx_data",         {24'd0, bus.tx_data},         {24'd0, m_tx_data});
            chk("attempt_idx",     {16'd0, bus.attempt_idx},     {16'd0, m_attempt_idx});
            chk("busy",            {31'd0, bus.busy},            {31'd0, m_busy});
            chk("done",            {31'd0, bus.done},            {31'd0, m_done});
        end
    end

    // ---------------- Event log for literal expectations ----------------
    int          tr_cnt, tr_first, tr_last, done_n, done_cyc, so_n, tx_n;
    int          so_cyc[8];
    logic [31:0] so_ofs[8];
    logic [15:0] so_idx[8];
    int          tx_cyc[8];
    logic [7:0]  tx_dat[8];

    initial forever begin
        @(posedge clk);
        #1;
        if (bus.tgt_reset === 1'b1) begin
            tr_cnt++;
            if (tr_first < 0) tr_first = cyc;
            tr_last = cyc;
        end
        if (bus.start_offset === 1'b1 && so_n < 8) begin
            so_cyc[so_n] = cyc; so_ofs[so_n] = bus.glitch_offset; so_idx[so_n] = bus.attempt_idx;
            so_n++;
        end
        if (bus.tx_start === 1'b1 && tx_n < 8) begin
            tx_cyc[tx_n] = cyc; tx_dat[tx_n] = bus.tx_data;
            tx_n++;
        end
        if (bus.done === 1'b1) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    int s0;
    int end_rel;

    // Launch one campaign and wait (bounded) until it is over
    task automatic run(input logic [31:0] base, input logic [31:0] step, input logic [31:0] dur,
                       input logic [15:0] n, input int mode, input int restart_at, input int abort_at);
        int rel;
        tr_cnt = 0; tr_first = -1; tr_last = -1; done_n = 0; done_cyc = -1; so_n = 0; tx_n = 0;
        pd_mode = mode;
        bus.ofs_base = base; bus.ofs_step = step; bus.glitch_dur = dur; bus.attempts = n;
        bus.start = 1'b1;
        s0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        forever begin
            rel = cyc - s0;
            bus.abort = (rel == abort_at);
            if (rel == restart_at) begin
                bus.ofs_base = 32'd7777; bus.attempts = 16'd9; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (rel >= 2 && !bus.busy) break;
            if (rel > 3000) break;
            @(negedge clk);
        end
        chk("campaign_ends", {31'd0, rel <= 3000}, 32'd1);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        end_rel = rel;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.ofs_base = 0; bus.ofs_step = 0;
        bus.glitch_dur = 0; bus.attempts = 0; bus.pulse_done = 0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        // Reset state
        chk("rst_tgt_reset",  {31'd0, bus.tgt_reset}, 32'd0);
        chk("rst_busy",       {31'd0, bus.busy},      32'd0);
        chk("rst_done",       {31'd0, bus.done},      32'd0);
        chk("rst_offset",     bus.glitch_offset,      32'd0);
        chk("rst_tx_data",    {24'd0, bus.tx_data},   32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single attempt: pulse_done 20 cycles after start_offset
        run(32'd10, 32'd5, 32'd3, 16'd1, 1, -1, -1);
        chk("single_tr_cnt",   tr_cnt, 4);
        chk("single_tr_first", tr_first - s0, 1);
        chk("single_tr_last",  tr_last - s0, 4);
        chk("single_so_n",     so_n, 1);
        chk("single_so_cyc",   so_cyc[0] - s0, 13);
        chk("single_so_ofs",   so_ofs[0], 32'd10);
        chk("single_tx_n",     tx_n, 1);
        chk("single_tx_dat",   {24'd0, tx_dat[0]}, 32'h55);
        chk("single_tx_cyc",   tx_cyc[0] - s0, 35);
        chk("single_done_n",   done_n, 1);
        chk("single_done_cyc", done_cyc - s0, 43);
        chk("single_dur",      bus.glitch_duration, 32'd3);

        // Sweep of three with an ignored start mid-campaign
        run(32'd100, 32'd50, 32'd7, 16'd3, 1, 20, -1);
        chk("sweep_so_n",  so_n, 3);
        chk("sweep_ofs0",  so_ofs[0], 32'd100);
        chk("sweep_ofs1",  so_ofs[1], 32'd150);
        chk("sweep_ofs2",  so_ofs[2], 32'd200);
        chk("sweep_idx1",  {16'd0, so_idx[1]}, 32'd1);
        chk("sweep_idx2",  {16'd0, so_idx[2]}, 32'd2);
        chk("sweep_tx_n",  tx_n, 3);
        chk("sweep_tx2",   {24'd0, tx_dat[2]}, 32'h55);
        chk("sweep_done",  done_n, 1);

        // Timeout on every attempt, campaign still advances
        run(32'd1, 32'd1, 32'd1, 16'd2, 0, -1, -1);
        chk("to_so_n",   so_n, 2);
        chk("to_tx_n",   tx_n, 2);
        chk("to_tx0",    {24'd0, tx_dat[0]}, 32'hEE);
        chk("to_tx1",    {24'd0, tx_dat[1]}, 32'hEE);
        chk("to_delay",  tx_cyc[0] - so_cyc[0], 102);
        chk("to_done",   done_n, 1);

        // Offset wrap and stale pulse_done level
        run(32'hFFFF_FFF0, 32'h20, 32'd9, 16'd2, 2, -1, -1);
        chk("wrap_ofs0",  so_ofs[0], 32'hFFFF_FFF0);
        chk("wrap_ofs1",  so_ofs[1], 32'h0000_0010);
        chk("stale_tx0",  {24'd0, tx_dat[0]}, 32'h55);
        chk("stale_delay", tx_cyc[0] - so_cyc[0], 17);

        // UART busy when the byte is ready
        run(32'd4, 32'd0, 32'd2, 16'd1, 3, -1, -1);
        chk("ubusy_tx_n",  tx_n, 1);
        chk("ubusy_delay", tx_cyc[0] - so_cyc[0], 37);
        chk("ubusy_dat",   {24'd0, tx_dat[0]}, 32'h55);

        // Abort during SETTLE of attempt 1
        run(32'd20, 32'd2, 32'd2, 16'd3, 1, -1, 48);
        chk("abort_end",   end_rel, 49);
        repeat (20) @(negedge clk);
        chk("abort_tr",    tr_cnt, 8);
        chk("abort_done",  done_n, 0);
        chk("abort_so_n",  so_n, 1);

        // Zero attempts
        run(32'd33, 32'd1, 32'd1, 16'd0, 1, -1, -1);
        chk("zero_done",   done_n, 1);
        chk("zero_cyc",    done_cyc - s0, 1);
        chk("zero_tr",     tr_cnt, 0);
        chk("zero_ofs",    bus.glitch_offset, 32'd33);

        // start together with abort in IDLE is ignored
        tr_cnt = 0;
        bus.attempts = 16'd1; bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("sa_busy", {31'd0, bus.busy}, 32'd0);
        chk("sa_tr",   tr_cnt, 0);

        // Reset in the middle of a campaign
        bus.ofs_base = 32'd5; bus.attempts = 16'd2; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mrst_ofs",  bus.glitch_offset, 32'd0);
        chk("mrst_tgt",  {31'd0, bus.tgt_reset}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
